fifo_synch_1wnr: RTL and testbench

Synchronous FIFO with one-word write and N-word read: the mirror of the team's N-write/1-read FIFO. It accepts one `width_p`-bit word per cycle on a valid-ready input. It presents the oldest `n_read_p` words as a packed vector on a valid-yumi output, which lets a producer emitting one coefficient per cycle feed an N-lane HE datapath stage. Storage is a circular buffer addressed by read and write pointers that each carry an extra wrap bit.

---
 rtl/fifo_synch_1wnr.sv | 80 ++++++++
 tb/tb_fifo_synch_1wnr.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fifo_synch_1wnr.sv
// rtl/fifo_synch_1wnr.sv - synchronous FIFO, one word in per cycle, n_read_p words out per dequeue
// Circular buffer with wrap-bit pointers; all outputs come from registered state only.

`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef N_READ
`define N_READ 4
`endif

module fifo_synch_1wnr #(
   parameter int width_p     = `BIT_WIDTH,
   parameter int ptr_width_p = 8,
   parameter int n_read_p    = `N_READ
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [width_p-1:0]                data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output logic                              valid_o,
   output logic [n_read_p-1:0][width_p-1:0]  data_o,
   input  logic                              yumi_i,
   output logic [ptr_width_p:0]              count_o
);

   localparam int cap_p = 1 << ptr_width_p;
   localparam logic [ptr_width_p:0] c_cap   = (ptr_width_p+1)'(cap_p);
   localparam logic [ptr_width_p:0] c_nread = (ptr_width_p+1)'(n_read_p);

   logic [width_p-1:0]  r_queue [cap_p];
   logic [ptr_width_p:0] r_read_ptr;
   logic [ptr_width_p:0] r_write_ptr;
   logic [ptr_width_p:0] r_count;
   logic [ptr_width_p:0] w_count_next;
   logic                 w_enq;
   logic                 w_deq;

   assign ready_o = (r_count != c_cap);
   assign valid_o = (r_count >= c_nread);
   assign count_o = r_count;

   assign w_enq = valid_i & ready_o;
   assign w_deq = yumi_i & valid_o;

   always_comb begin
      w_count_next = r_count;
      unique case ({w_enq, w_deq})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - c_nread;
         2'b11:   w_count_next = r_count + 1'b1 - c_nread;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_read_ptr  <= '0;
         r_write_ptr <= '0;
         r_count     <= '0;
      end else begin
         if (w_enq) r_write_ptr <= r_write_ptr + 1'b1;
         if (w_deq) r_read_ptr  <= r_read_ptr + c_nread;
         r_count <= w_count_next;
      end
   end

   // Memory is never cleared; only the pointers are reset.
   always_ff @(posedge clk_i) begin
      if (w_enq && !reset_i)
         r_queue[r_write_ptr[ptr_width_p-1:0]] <= data_i;
   end

   for (genvar gi = 0; gi < n_read_p; gi++) begin : g_lane
      logic [ptr_width_p-1:0] w_addr;
      assign w_addr     = r_read_ptr[ptr_width_p-1:0] + ptr_width_p'(gi);
      assign data_o[gi] = r_queue[w_addr];
   end

endmodule

// File: tb/tb_fifo_synch_1wnr.sv
// tb/tb_fifo_synch_1wnr.sv - directed self-checking bench for fifo_synch_1wnr
// Configuration: 16-bit words, capacity 8, four words per dequeue.

module tb_fifo_synch_1wnr;

   logic             clk_i = 1'b0;
   logic             reset_i;
   logic [15:0]      data_i;
   logic             valid_i;
   logic             ready_o;
   logic             valid_o;
   logic [3:0][15:0] data_o;
   logic             yumi_i;
   logic [3:0]       count_o;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_synch_1wnr #(
      .width_p     (16),
      .ptr_width_p (3),
      .n_read_p    (4)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .data_o  (data_o),
      .yumi_i  (yumi_i),
      .count_o (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [15:0] d);
      valid_i = 1'b1;
      data_i  = d;
      step();
      valid_i = 1'b0;
   endtask

   task automatic yumi();
      yumi_i = 1'b1;
      step();
      yumi_i = 1'b0;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
   endtask

   initial begin
      reset_i = 1'b0;
      data_i  = '0;
      valid_i = 1'b0;
      yumi_i  = 1'b0;
      #1;
      do_reset();
      check("reset_count", 64'(count_o), 64'd0);
      check("reset_ready", 64'(ready_o), 64'd1);
      check("reset_valid", 64'(valid_o), 64'd0);

      // fill to valid
      write_word(16'h0A);
      write_word(16'h0B);
      write_word(16'h0C);
      check("fill3_valid", 64'(valid_o), 64'd0);
      check("fill3_count", 64'(count_o), 64'd3);
      write_word(16'h0D);
      check("fill4_valid", 64'(valid_o), 64'd1);
      check("fill4_count", 64'(count_o), 64'd4);
      check("fill4_data", data_o, 64'h000D_000C_000B_000A);
      yumi();
      check("fill_yumi_count", 64'(count_o), 64'd0);
      check("fill_yumi_valid", 64'(valid_o), 64'd0);

      // full, starting from address 4
      for (int i = 1; i <= 8; i++) write_word(16'(i));
      check("full_ready", 64'(ready_o), 64'd0);
      check("full_count", 64'(count_o), 64'd8);
      write_word(16'hFF);
      check("full_drop_count", 64'(count_o), 64'd8);
      check("full_data0", data_o, 64'h0004_0003_0002_0001);
      yumi();
      check("full_ready_after", 64'(ready_o), 64'd1);
      check("full_data1", data_o, 64'h0008_0007_0006_0005);
      yumi();
      check("full_empty_count", 64'(count_o), 64'd0);

      // wrap-around read from a fresh reset
      do_reset();
      for (int i = 1; i <= 6; i++) write_word(16'(i));
      yumi();
      check("wrap_mid_count", 64'(count_o), 64'd2);
      for (int i = 0; i < 6; i++) write_word(16'h11 + 16'(i));
      check("wrap_count", 64'(count_o), 64'd8);
      check("wrap_ready", 64'(ready_o), 64'd0);
      check("wrap_data0", data_o, 64'h0012_0011_0006_0005);
      yumi();
      check("wrap_data1", data_o, 64'h0016_0015_0014_0013);
      yumi();
      check("wrap_empty_count", 64'(count_o), 64'd0);

      // ignored yumi with too few words
      write_word(16'h21);
      write_word(16'h22);
      write_word(16'h23);
      yumi();
      check("ign_count", 64'(count_o), 64'd3);
      check("ign_valid", 64'(valid_o), 64'd0);

      // simultaneous enqueue and dequeue
      write_word(16'h24);
      write_word(16'h25);
      check("sim_pre_count", 64'(count_o), 64'd5);
      check("sim_pre_data", data_o, 64'h0024_0023_0022_0021);
      valid_i = 1'b1;
      data_i  = 16'h77;
      yumi_i  = 1'b1;
      step();
      valid_i = 1'b0;
      yumi_i  = 1'b0;
      check("sim_count", 64'(count_o), 64'd2);
      write_word(16'h78);
      write_word(16'h79);
      check("sim_post_data", data_o, 64'h0079_0078_0077_0025);

      // reset mid-operation with a concurrent write
      write_word(16'h7A);
      write_word(16'h7B);
      check("rst_pre_count", 64'(count_o), 64'd6);
      reset_i = 1'b1;
      valid_i = 1'b1;
      data_i  = 16'hEE;
      step();
      reset_i = 1'b0;
      valid_i = 1'b0;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_valid", 64'(valid_o), 64'd0);
      write_word(16'h0A);
      write_word(16'h0B);
      write_word(16'h0C);
      check("refill3_valid", 64'(valid_o), 64'd0);
      write_word(16'h0D);
      check("refill_valid", 64'(valid_o), 64'd1);
      check("refill_data", data_o, 64'h000D_000C_000B_000A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
